// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the frame buffer controller.
// Holds the default sizing and the controller state encoding.
// Contents: FB_DATA_W, FB_ADDR_W, FB_FRAME_PIXELS, fb_state_t.
package frame_buffer_pkg;

    localparam int FB_DATA_W       = 8;
    localparam int FB_ADDR_W       = 15;
    localparam int FB_FRAME_PIXELS = 19200;  // 160x120

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READY   = 2'd2,
        ST_READOUT = 2'd3
    } fb_state_t;

endpackage

// File: rtl/fb_addr_counter.sv
// Frame address counter: clear, increment, terminal count at FRAME_PIXELS-1.
// Ports: clk/rst, clr (restart at 0 this cycle), inc (advance), cur (address
//        to use this cycle, already reflecting clr), tc (cur is the last pixel).
// The count wraps to 0 after the last pixel, so it never exceeds FRAME_PIXELS-1.
module fb_addr_counter #(
    parameter int ADDR_W       = 15,
    parameter int FRAME_PIXELS = 19200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] cur,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // A clear and an increment in the same cycle means "use address 0 now",
    // so the stored count becomes 1 (or wraps for a one-pixel frame).
    always_comb begin
        cur   = clr ? '0 : cnt_q;
        tc    = (cur == LAST);
        cnt_d = cur;
        if (inc) begin
            cnt_d = tc ? '0 : cur + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Single-frame buffer between a camera and a pixel consumer over an external RAM.
// Ports: i_clk/i_rst; camera i_Cam_Frame_Start/i_Cam_Valid/i_Cam_Data; consumer
//        i_Rd_Req -> o_Rd_Data/o_Rd_Valid (1 cycle after read enable); status
//        o_Frame_Ready, sticky o_Overflow; RAM write/read address, data, enables.
// Macro FRAME_BUFFER_CTRL_WRAP_READ_EN: readout wraps to READY for repeated refresh and
// a frame start during READY/READOUT recaptures instead of flagging overflow.
module frame_buffer_ctrl
    import frame_buffer_pkg::*;
#(
    parameter int DATA_W       = FB_DATA_W,
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int FRAME_PIXELS = FB_FRAME_PIXELS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_Cam_Frame_Start,
    input  logic              i_Cam_Valid,
    input  logic [DATA_W-1:0] i_Cam_Data,
    input  logic              i_Rd_Req,
    output logic [DATA_W-1:0] o_Rd_Data,
    output logic              o_Rd_Valid,
    output logic              o_Frame_Ready,
    output logic              o_Overflow,
    output logic [ADDR_W-1:0] o_Ram_Write_Adress,
    output logic [ADDR_W-1:0] o_Ram_Read_Adress,
    output logic [DATA_W-1:0] o_Ram_Data,
    output logic              o_Ram_Enable_Write,
    output logic              o_Ram_Enable_Read,
    input  logic [DATA_W-1:0] i_Ram_Data
);

`ifdef FRAME_BUFFER_CTRL_WRAP_READ_EN
    localparam bit WRAP_READ = 1'b1;
`else
    localparam bit WRAP_READ = 1'b0;
`endif

    fb_state_t state_q, state_d;

    logic in_capture, in_read;
    logic restart, drop, wr_en, rd_en, frame_done, rd_last;
    logic [ADDR_W-1:0] wr_cur, rd_cur;
    logic              wr_tc, rd_tc;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic              frame_ready_q, frame_ready_d;
    logic              overflow_q, overflow_d;

    // Event decode shared by the next-state and output logic.
    always_comb begin
        in_capture = (state_q == ST_CAPTURE);
        in_read    = (state_q == ST_READY) || (state_q == ST_READOUT);
        // A start pulse while a frame is held is either a drop or a recapture.
        restart    = i_Cam_Frame_Start && (!in_read || WRAP_READ);
        drop       = i_Cam_Frame_Start && in_read && !WRAP_READ;
        // Start and valid together write the first pixel at address 0.
        wr_en      = i_Cam_Valid && (restart || in_capture);
        // A recapture aborts a read requested in the same cycle.
        rd_en      = i_Rd_Req && in_read && !restart;
        frame_done = wr_en && wr_tc;
        rd_last    = rd_en && rd_tc;
    end

    fb_addr_counter #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_wr_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .clr (restart),
        .inc (wr_en),
        .cur (wr_cur),
        .tc  (wr_tc)
    );

    fb_addr_counter #(
        .ADDR_W       (ADDR_W),
        .FRAME_PIXELS (FRAME_PIXELS)
    ) u_rd_cnt (
        .clk (i_clk),
        .rst (i_rst),
        .clr (frame_done),
        .inc (rd_en),
        .cur (rd_cur),
        .tc  (rd_tc)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_CAPTURE: begin
                if (frame_done) begin
                    state_d = ST_READY;
                end else if (restart) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_READY, ST_READOUT: begin
                if (frame_done) begin
                    state_d = ST_READY;
                end else if (restart) begin
                    state_d = ST_CAPTURE;
                end else if (rd_last) begin
                    state_d = WRAP_READ ? ST_READY : ST_IDLE;
                end else if (rd_en) begin
                    state_d = ST_READOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    // Addresses and write data hold when their enable is low.
    always_comb begin
        wr_en_d       = wr_en;
        wr_addr_d     = wr_en ? wr_cur : wr_addr_q;
        wr_data_d     = wr_en ? i_Cam_Data : wr_data_q;
        rd_en_d       = rd_en;
        rd_addr_d     = rd_en ? rd_cur : rd_addr_q;
        rd_vld_d      = rd_en_q;
        overflow_d    = overflow_q | drop;
        frame_ready_d = frame_ready_q;
        if (frame_done) begin
            frame_ready_d = 1'b1;
        end else if (restart) begin
            frame_ready_d = 1'b0;
        end else if (rd_last && !WRAP_READ) begin
            frame_ready_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_vld_q      <= 1'b0;
            frame_ready_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            rd_vld_q      <= rd_vld_d;
            frame_ready_q <= frame_ready_d;
            overflow_q    <= overflow_d;
        end
    end

    assign o_Ram_Enable_Write = wr_en_q;
    assign o_Ram_Write_Adress = wr_addr_q;
    assign o_Ram_Data         = wr_data_q;
    assign o_Ram_Enable_Read  = rd_en_q;
    assign o_Ram_Read_Adress  = rd_addr_q;
    assign o_Rd_Valid         = rd_vld_q;
    // RAM returns data the cycle after the enable; gate it so it reads 0 when idle.
    assign o_Rd_Data          = rd_vld_q ? i_Ram_Data : '0;
    assign o_Frame_Ready      = frame_ready_q;
    assign o_Overflow         = overflow_q;

endmodule
